ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  EX-stage multi-cycle multiply/divide unit with the HI/LO architectural registers.
//  Consumes operands, funct and the decoded valid from the ID/EX pipeline register.
//  Runs MULT/MULTU/DIV/DIVU and MTHI/MTLO, and serves MFHI/MFLO.
//  Raises stall_o so that hazard control freezes the front-end while HI/LO are pending.
// PARAMETERS
//  XLEN        32  operand width; HI and LO are each XLEN bits
//  MUL_CYCLES  4   multiply latency in cycles after accept; legal range 1..16
// PORTS
//  Clk        in   1     clock; all state updates on posedge
//  Rst        in   1     synchronous reset, active-high
//  op_valid_i in   1     ID/EX holds a valid HI/LO-class instruction this cycle
//  funct_i    in   6     MIPS funct: 18h MULT, 19h MULTU, 1Ah DIV, 1Bh DIVU, 10h MFHI, 11h MTHI, 12h MFLO, 13h MTLO
//  opa_i      in   XLEN  rs operand: dividend / multiplicand / MTxx source
//  opb_i      in   XLEN  rt operand: divisor / multiplier
//  stall_o    out  1     hold upstream; op_valid_i & hilo-class funct & busy_o
//  busy_o     out  1     state != IDLE
//  done_o     out  1     one-cycle pulse on the edge HI/LO are written by MUL/DIV
//  hi_o       out  XLEN  HI register
//  lo_o       out  XLEN  LO register
//  mf_data_o  out  XLEN  combinational: hi_o when funct=10h, lo_o when 12h, else 0
//  flush_i    in   1     only present when MULDIV_ABORT_EN is defined
// BEHAVIOUR
//  Reset: state=IDLE; hi_o=lo_o=0; busy_o=done_o=stall_o=0; iteration counter=0.
//  States: IDLE -> MUL -> IDLE; IDLE -> DIV -> FIX -> IDLE.
//  Accept: in IDLE with op_valid_i and funct in 18h..1Bh. Operands are latched at edge E0.
//  MUL: count MUL_CYCLES edges. At edge E(MUL_CYCLES), {HI,LO} <= 2*XLEN-bit product, done_o=1.
//   MULT is signed; MULTU is unsigned.
//  DIV: restoring radix-2 on operand magnitudes; XLEN iteration edges, then FIX applies signs.
//   At edge E(XLEN+1) (E33 at default XLEN), LO <= quotient, HI <= remainder, done_o=1.
//   Quotient sign = sign(a) ^ sign(b); remainder sign = sign(a) (DIV only).
//  Divide by zero: LO <= all-ones, HI <= opa (signed and unsigned alike).
//  DIV overflow (80000000h / FFFFFFFFh): LO <= 80000000h, HI <= 0.
//  MTHI/MTLO: in IDLE with op_valid_i, HI/LO <= opa_i at the next edge. No busy, no done.
//  MFHI/MFLO/MTHI/MTLO/new mul-div while busy: stall_o=1, no action. Upstream holds inputs.
//  New op on the same edge the unit returns to IDLE: stall_o=1 that cycle, accepted next cycle.
//  MFxx after done_o: reads the new value; HI/LO update at the done edge.
//  Non-hilo funct or op_valid_i=0: ignored. stall_o=0.
//  Rst asserted mid-operation: abort to reset values on that edge. HI/LO are cleared.
// CONFIGURATION
//  MULDIV_ABORT_EN defined: adds the flush_i port.
//   flush_i=1 in MUL/DIV/FIX -> IDLE next edge; HI/LO keep their pre-op values; no done_o.
//   flush_i in IDLE blocks an accept or MTxx write in that cycle.
//   Rst takes priority over flush_i.
//  MULDIV_ABORT_EN undefined: no flush_i port; every accepted op runs to completion.
// TESTING
//  1 Reset: Rst high 2 cycles -> hi_o=lo_o=0, busy_o=0, stall_o=0.
//  2 MULT FFFFFFFEh*00000003h -> done_o at E4 with HI=FFFFFFFFh, LO=FFFFFFFAh.
//    MULTU with the same operands -> HI=00000002h, LO=FFFFFFFAh.
//  3 DIV FFFFFFF9h/00000002h (-7/2) -> done_o at E33 with LO=FFFFFFFDh, HI=FFFFFFFFh.
//    DIVU 100/7 -> LO=14, HI=2.
//  4 Edge cases: DIV 80000000h/FFFFFFFFh -> LO=80000000h, HI=0.
//    DIVU 5/0 -> LO=FFFFFFFFh, HI=5.
//  5 MFLO issued 1 cycle after DIV accept -> stall_o high through E33.
//    mf_data_o = new LO in the first unstalled cycle. Back-to-back MULT is held until IDLE.
//  6 Abort (macro on): flush_i at E10 of DIV -> IDLE at E11, HI/LO unchanged, no done_o.
//    Rst at E10 (macro off) -> HI/LO=0, busy_o=0.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Purpose : EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
// Latency : MUL writes {HI,LO} MUL_CYCLES edges after accept; DIV writes XLEN+1 edges after accept; MTxx writes on the next edge.
// Backpr. : stall_o freezes the front-end while a HI/LO-class op meets a busy unit; a stalled op is held upstream and retried.
//
// Ports:
//   Clk, Rst            clock and synchronous active-high reset
//   op_valid_i          ID/EX holds a valid instruction this cycle
//   funct_i             MIPS funct (18h..1Bh mul/div, 10h..13h MFHI/MTHI/MFLO/MTLO)
//   opa_i, opb_i        rs / rt operands
//   stall_o, busy_o     hold-upstream request and unit-busy flag
//   done_o              one-cycle pulse on the edge that writes HI/LO from a MUL/DIV
//   hi_o, lo_o          HI/LO architectural registers
//   mf_data_o           combinational MFHI/MFLO read data
//   flush_i             abort input, present only when MULDIV_ABORT_EN is defined
//
// Build option: define MULDIV_ABORT_EN to add flush_i (abort an in-flight op, block IDLE writes).

module ex_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            op_valid_i,
    input  logic [5:0]      funct_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
`ifdef MULDIV_ABORT_EN
    input  logic            flush_i,
`endif
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic [XLEN-1:0] mf_data_o
);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_DIV   = 6'h1A;

    // Counter is wide enough for XLEN-1 and MUL_CYCLES-1 (MUL_CYCLES <= 16).
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] op_a;       // raw rs operand (multiplicand, or dividend for the /0 result)
    logic [XLEN-1:0] op_b;       // multiplier, or divisor magnitude for DIV/DIVU
    logic [XLEN-1:0] quo;        // dividend magnitude shifting out, quotient shifting in
    logic [XLEN-1:0] rem;        // partial remainder
    logic            mul_signed;
    logic            neg_q;
    logic            neg_r;

    logic            flush_w;
    logic            is_muldiv;
    logic            is_hilo;
    logic            opa_neg;
    logic            opb_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [2*XLEN-1:0] ext_a;
    logic [2*XLEN-1:0] ext_b;
    logic [2*XLEN-1:0] product;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

`ifdef MULDIV_ABORT_EN
    assign flush_w = flush_i;
`else
    assign flush_w = 1'b0;
`endif

    // 18h..1Bh share funct[5:2]=0110; 10h..13h share funct[5:2]=0100.
    assign is_muldiv = (funct_i[5:2] == 4'b0110);
    assign is_hilo   = is_muldiv || (funct_i[5:2] == 4'b0100);

    assign busy_o  = (state != S_IDLE);
    assign stall_o = op_valid_i && is_hilo && busy_o;

    always_comb begin
        mf_data_o = '0;
        if (funct_i == F_MFHI) begin
            mf_data_o = hi_o;
        end else if (funct_i == F_MFLO) begin
            mf_data_o = lo_o;
        end
    end

    // Only signed DIV takes operand magnitudes; DIVU uses the raw bits.
    assign opa_neg = (funct_i == F_DIV) && opa_i[XLEN-1];
    assign opb_neg = (funct_i == F_DIV) && opb_i[XLEN-1];
    assign mag_a   = opa_neg ? -opa_i : opa_i;
    assign mag_b   = opb_neg ? -opb_i : opb_i;

    // Sign- or zero-extend to 2*XLEN; the truncated product is then exact for both.
    assign ext_a   = mul_signed ? {{XLEN{op_a[XLEN-1]}}, op_a} : {{XLEN{1'b0}}, op_a};
    assign ext_b   = mul_signed ? {{XLEN{op_b[XLEN-1]}}, op_b} : {{XLEN{1'b0}}, op_b};
    assign product = ext_a * ext_b;

    // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, op_b};

    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            quo        <= '0;
            rem        <= '0;
            mul_signed <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid_i && !flush_w) begin
                        if (is_muldiv) begin
                            cnt  <= '0;
                            op_a <= opa_i;
                            if (!funct_i[1]) begin
                                op_b       <= opb_i;
                                mul_signed <= (funct_i == F_MULT);
                                state      <= S_MUL;
                            end else begin
                                op_b  <= mag_b;
                                quo   <= mag_a;
                                rem   <= '0;
                                neg_q <= opa_neg ^ opb_neg;
                                neg_r <= opa_neg;
                                state <= S_DIV;
                            end
                        end else if (funct_i == F_MTHI) begin
                            hi_o <= opa_i;
                        end else if (funct_i == F_MTLO) begin
                            lo_o <= opa_i;
                        end
                    end
                end

                S_MUL: begin
                    if (flush_w) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == MUL_LAST) begin
                        {hi_o, lo_o} <= product;
                        done_o       <= 1'b1;
                        state        <= S_IDLE;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_DIV: begin
                    if (flush_w) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        if (!diff[XLEN]) begin
                            rem <= diff[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b1};
                        end else begin
                            rem <= shifted[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b0};
                        end
                        if (cnt == DIV_LAST) begin
                            state <= S_FIX;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                S_FIX: begin
                    if (!flush_w) begin
                        // A zero divisor returns all-ones / raw dividend regardless of sign mode.
                        // The overflow case (most-negative / -1) falls out of the magnitude path.
                        if (op_b == '0) begin
                            lo_o <= '1;
                            hi_o <= op_a;
                        end else begin
                            lo_o <= q_fix;
                            hi_o <= r_fix;
                        end
                        done_o <= 1'b1;
                    end
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        op_valid_i;
    logic [5:0]  funct_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
`ifdef MULDIV_ABORT_EN
    logic        flush_i;
`endif
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] mf_data_o;

    int n_checks = 0;
    int n_fail   = 0;

    ex_muldiv_unit #(.XLEN(32), .MUL_CYCLES(4)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .op_valid_i (op_valid_i),
        .funct_i    (funct_i),
        .opa_i      (opa_i),
        .opb_i      (opb_i),
`ifdef MULDIV_ABORT_EN
        .flush_i    (flush_i),
`endif
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .mf_data_o  (mf_data_o)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: architectural result {HI,LO} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] res;
        longint      sp;
        int          q;
        int          r;
        res = '0;
        case (f)
            F_MULT: begin
                sp  = longint'($signed(a)) * longint'($signed(b));
                res = sp;
            end
            F_MULTU: res = {32'h0, a} * {32'h0, b};
            F_DIV: begin
                if (b == 32'h0)                                    res = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF)   res = {32'h0, 32'h80000000};
                else begin
                    q   = $signed(a) / $signed(b);
                    r   = $signed(a) % $signed(b);
                    res = {r, q};
                end
            end
            F_DIVU: begin
                if (b == 32'h0) res = {a, 32'hFFFFFFFF};
                else            res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Issue one mul/div on an idle unit; report edges from accept to done_o (-1 if never seen).
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output int lat);
        @(negedge Clk);
        op_valid_i = 1'b1; funct_i = f; opa_i = a; opb_i = b;
        @(posedge Clk);
        @(negedge Clk);
        op_valid_i = 1'b0; funct_i = 6'h00;
        lat = -1; hi = '0; lo = '0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (done_o) begin
                lat = i; hi = hi_o; lo = lo_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; op_valid_i = 1'b0; funct_i = 6'h00; opa_i = '0; opb_i = '0;
`ifdef MULDIV_ABORT_EN
        flush_i = 1'b0;
`endif
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        n_checks++; if (hi_o !== 32'h0)  begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi_o); end
        n_checks++; if (lo_o !== 32'h0)  begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
        op_valid_i = 1'b1; funct_i = F_MFHI;
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        op_valid_i = 1'b0; funct_i = 6'h00;
        Rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [31:0] hi, lo, a, b;
        logic [5:0]  f;
        logic [63:0] exp;
        int          lat;
        run_op(F_MULT, 32'hFFFFFFFE, 32'h3, hi, lo, lat);
        n_checks++; if (lat !== 4)            begin n_fail++; $display("FAIL mult_lat: got %0d want 4", lat); end
        n_checks++; if (hi !== 32'hFFFFFFFF)  begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFFFFFA)  begin n_fail++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
        run_op(F_MULTU, 32'hFFFFFFFE, 32'h3, hi, lo, lat);
        n_checks++; if (hi !== 32'h2)         begin n_fail++; $display("FAIL multu_hi: got %h want 2", hi); end
        n_checks++; if (lo !== 32'hFFFFFFFA)  begin n_fail++; $display("FAIL multu_lo: got %h want fffffffa", lo); end
        for (int i = 0; i < 10; i++) begin
            f = ($urandom_range(0, 1) == 1) ? F_MULT : F_MULTU;
            a = $urandom; b = $urandom;
            if (i < 3) b = $urandom_range(0, 15);
            exp = model(f, a, b);
            run_op(f, a, b, hi, lo, lat);
            n_checks++;
            if ({hi, lo} !== exp || lat !== 4) begin
                n_fail++;
                $display("FAIL mul_rand: f=%h a=%h b=%h got %h_%h lat %0d want %h lat 4", f, a, b, hi, lo, lat, exp);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] hi, lo, a, b;
        logic [5:0]  f;
        logic [63:0] exp;
        int          lat;
        run_op(F_DIV, 32'hFFFFFFF9, 32'h2, hi, lo, lat);
        n_checks++; if (lat !== 33)           begin n_fail++; $display("FAIL div_lat: got %0d want 33", lat); end
        n_checks++; if (lo !== 32'hFFFFFFFD)  begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFFFFFF)  begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        run_op(F_DIVU, 32'd100, 32'd7, hi, lo, lat);
        n_checks++; if (lo !== 32'd14)        begin n_fail++; $display("FAIL divu_lo: got %0d want 14", lo); end
        n_checks++; if (hi !== 32'd2)         begin n_fail++; $display("FAIL divu_hi: got %0d want 2", hi); end
        for (int i = 0; i < 10; i++) begin
            f = ($urandom_range(0, 1) == 1) ? F_DIV : F_DIVU;
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 1000) : $urandom;
            if (i == 0) b = -32'sd3;
            exp = model(f, a, b);
            run_op(f, a, b, hi, lo, lat);
            n_checks++;
            if ({hi, lo} !== exp || lat !== 33) begin
                n_fail++;
                $display("FAIL div_rand: f=%h a=%h b=%h got %h_%h lat %0d want %h lat 33", f, a, b, hi, lo, lat, exp);
            end
        end
    endtask

    task automatic test_edge();
        logic [31:0] hi, lo;
        int          lat;
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, hi, lo, lat);
        n_checks++; if (lo !== 32'h80000000)  begin n_fail++; $display("FAIL ovf_lo: got %h want 80000000", lo); end
        n_checks++; if (hi !== 32'h0)         begin n_fail++; $display("FAIL ovf_hi: got %h want 0", hi); end
        run_op(F_DIVU, 32'd5, 32'd0, hi, lo, lat);
        n_checks++; if (lo !== 32'hFFFFFFFF)  begin n_fail++; $display("FAIL divu0_lo: got %h want ffffffff", lo); end
        n_checks++; if (hi !== 32'd5)         begin n_fail++; $display("FAIL divu0_hi: got %h want 5", hi); end
        run_op(F_DIV, 32'hFFFFFFFB, 32'd0, hi, lo, lat);
        n_checks++; if (lo !== 32'hFFFFFFFF)  begin n_fail++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
        n_checks++; if (hi !== 32'hFFFFFFFB)  begin n_fail++; $display("FAIL div0_hi: got %h want fffffffb", hi); end
        @(negedge Clk);
        n_checks++; if (done_o !== 1'b0)      begin n_fail++; $display("FAIL done_pulse: got %b want 0", done_o); end
    endtask

    task automatic test_mt();
        logic [31:0] v_hi, v_lo;
        v_hi = $urandom; v_lo = $urandom;
        @(negedge Clk);
        op_valid_i = 1'b1; funct_i = F_MTHI; opa_i = v_hi;
        @(posedge Clk);
        @(negedge Clk);
        n_checks++; if (hi_o !== v_hi)   begin n_fail++; $display("FAIL mthi: got %h want %h", hi_o, v_hi); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mt_busy: got %b want 0", busy_o); end
        funct_i = F_MTLO; opa_i = v_lo;
        @(posedge Clk);
        @(negedge Clk);
        n_checks++; if (lo_o !== v_lo)   begin n_fail++; $display("FAIL mtlo: got %h want %h", lo_o, v_lo); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL mt_done: got %b want 0", done_o); end
        funct_i = F_MFHI; opa_i = $urandom;
        #1;
        n_checks++; if (mf_data_o !== v_hi) begin n_fail++; $display("FAIL mfhi: got %h want %h", mf_data_o, v_hi); end
        n_checks++; if (stall_o !== 1'b0)   begin n_fail++; $display("FAIL mf_idle_stall: got %b want 0", stall_o); end
        funct_i = F_MFLO;
        #1;
        n_checks++; if (mf_data_o !== v_lo) begin n_fail++; $display("FAIL mflo: got %h want %h", mf_data_o, v_lo); end
        funct_i = 6'h20;
        #1;
        n_checks++; if (mf_data_o !== 32'h0) begin n_fail++; $display("FAIL mf_other: got %h want 0", mf_data_o); end
        op_valid_i = 1'b0; funct_i = 6'h00;
    endtask

    task automatic test_stall_mf();
        logic [31:0] a, b;
        logic [63:0] exp;
        int          stalled;
        a = $urandom; b = $urandom_range(1, 5000);
        exp = model(F_DIV, a, b);
        @(negedge Clk);
        op_valid_i = 1'b1; funct_i = F_DIV; opa_i = a; opb_i = b;
        @(posedge Clk);
        @(negedge Clk);
        funct_i = F_MFLO;
        stalled = 0;
        for (int i = 0; i < 100; i++) begin
            if (!stall_o) break;
            stalled++;
            @(posedge Clk);
            @(negedge Clk);
        end
        n_checks++; if (stalled !== 33)        begin n_fail++; $display("FAIL mflo_stall_cycles: got %0d want 33", stalled); end
        n_checks++; if (done_o !== 1'b1)       begin n_fail++; $display("FAIL mflo_done: got %b want 1", done_o); end
        n_checks++; if (mf_data_o !== exp[31:0]) begin n_fail++; $display("FAIL mflo_data: got %h want %h", mf_data_o, exp[31:0]); end
        op_valid_i = 1'b0; funct_i = 6'h00;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, ma, mb, mt;
        logic [63:0] exp_d, exp_m;
        int          stalled;
        a = $urandom; b = $urandom; ma = $urandom; mb = $urandom; mt = $urandom;
        exp_d = model(F_DIVU, a, b);
        exp_m = model(F_MULT, ma, mb);
        @(negedge Clk);
        op_valid_i = 1'b1; funct_i = F_DIVU; opa_i = a; opb_i = b;
        @(posedge Clk);
        @(negedge Clk);
        funct_i = F_MULT; opa_i = ma; opb_i = mb;
        stalled = 0;
        for (int i = 0; i < 100; i++) begin
            if (!stall_o) break;
            stalled++;
            @(posedge Clk);
            @(negedge Clk);
        end
        n_checks++; if (stalled !== 33)         begin n_fail++; $display("FAIL b2b_div_stall: got %0d want 33", stalled); end
        n_checks++; if ({hi_o, lo_o} !== exp_d) begin n_fail++; $display("FAIL b2b_div_res: got %h_%h want %h", hi_o, lo_o, exp_d); end
        @(posedge Clk);
        @(negedge Clk);
        funct_i = F_MTHI; opa_i = mt;
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_mul_accept: busy got %b want 1", busy_o); end
        stalled = 0;
        for (int i = 0; i < 100; i++) begin
            if (!stall_o) break;
            stalled++;
            @(posedge Clk);
            @(negedge Clk);
        end
        n_checks++; if (stalled !== 4)          begin n_fail++; $display("FAIL b2b_mul_stall: got %0d want 4", stalled); end
        n_checks++; if (done_o !== 1'b1)        begin n_fail++; $display("FAIL b2b_mul_done: got %b want 1", done_o); end
        n_checks++; if ({hi_o, lo_o} !== exp_m) begin n_fail++; $display("FAIL b2b_mul_res: got %h_%h want %h", hi_o, lo_o, exp_m); end
        @(posedge Clk);
        @(negedge Clk);
        op_valid_i = 1'b0; funct_i = 6'h00;
        n_checks++; if (hi_o !== mt)            begin n_fail++; $display("FAIL b2b_mthi: got %h want %h", hi_o, mt); end
        n_checks++; if (lo_o !== exp_m[31:0])   begin n_fail++; $display("FAIL b2b_lo_kept: got %h want %h", lo_o, exp_m[31:0]); end
    endtask

    task automatic test_abort();
        logic [31:0] p_hi, p_lo;
        bit          seen_done;
        p_hi = $urandom | 32'h1; p_lo = $urandom | 32'h1;
        @(negedge Clk);
        op_valid_i = 1'b1; funct_i = F_MTHI; opa_i = p_hi;
        @(posedge Clk);
        @(negedge Clk);
        funct_i = F_MTLO; opa_i = p_lo;
        @(posedge Clk);
        @(negedge Clk);
`ifdef MULDIV_ABORT_EN
        funct_i = F_MTHI; opa_i = ~p_hi; flush_i = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        flush_i = 1'b0;
        n_checks++; if (hi_o !== p_hi) begin n_fail++; $display("FAIL flush_idle_mthi: got %h want %h", hi_o, p_hi); end
`endif
        funct_i = F_DIV; opa_i = $urandom; opb_i = $urandom_range(1, 99);
        @(posedge Clk);
        @(negedge Clk);
        op_valid_i = 1'b0; funct_i = 6'h00;
        seen_done = 1'b0;
`ifdef MULDIV_ABORT_EN
        repeat (10) begin
            @(posedge Clk);
            @(negedge Clk);
            if (done_o) seen_done = 1'b1;
        end
        flush_i = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        flush_i = 1'b0;
        if (done_o) seen_done = 1'b1;
        repeat (30) begin
            @(posedge Clk);
            @(negedge Clk);
            if (done_o) seen_done = 1'b1;
        end
        n_checks++; if (busy_o !== 1'b0)    begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy_o); end
        n_checks++; if (hi_o !== p_hi)      begin n_fail++; $display("FAIL flush_hi: got %h want %h", hi_o, p_hi); end
        n_checks++; if (lo_o !== p_lo)      begin n_fail++; $display("FAIL flush_lo: got %h want %h", lo_o, p_lo); end
        n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b want 0", seen_done); end
`else
        repeat (9) begin
            @(posedge Clk);
            @(negedge Clk);
            if (done_o) seen_done = 1'b1;
        end
        Rst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        n_checks++; if (hi_o !== 32'h0)     begin n_fail++; $display("FAIL rst_mid_hi: got %h want 0", hi_o); end
        n_checks++; if (lo_o !== 32'h0)     begin n_fail++; $display("FAIL rst_mid_lo: got %h want 0", lo_o); end
        n_checks++; if (busy_o !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
        n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", seen_done); end
`endif
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_edge();
        test_mt();
        test_stall_mf();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
